// File: rtl/usb_fs_tx_arbiter.sv
// Round-robin arbiter sharing the full-speed USB tx serializer among protocol engines.
// Optional inter-packet gap state enabled by defining USB_TX_ARB_IPG_EN.
module usb_fs_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IPG_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_pkt_start,
  input  logic [4*NUM_REQ-1:0] req_pid,
  input  logic [NUM_REQ-1:0]   req_data_avail,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_data_get,
  output logic [NUM_REQ-1:0]   req_pkt_end,
  output logic                 tx_pkt_start,
  output logic [3:0]           tx_pid,
  output logic                 tx_data_avail,
  output logic [7:0]           tx_data,
  input  logic                 tx_data_get,
  input  logic                 tx_pkt_end,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int LG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > IPG_CYCLES) ? TIMEOUT_CYCLES : IPG_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
`ifdef USB_TX_ARB_IPG_EN
    , GAP  = 2'd2
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           rst_sync;
  logic                 rst_int_n;
  logic [NUM_REQ-1:0]   pending;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [NUM_REQ-1:0]   pick_clr;
  logic [3:0]           pid_q [NUM_REQ];
  logic [LG_W-1:0]      last_grant;
  logic [LG_W-1:0]      pick;
  logic                 pick_vld;
  logic [CNT_W-1:0]     counter;
  logic                 wd_fire;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // First pending index after the previous owner, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!pick_vld && pending[idx]) begin
        pick     = LG_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_oh[i] = (pick == LG_W'(i));
  end

  assign pick_clr = (state == IDLE && pick_vld) ? pick_oh : '0;
  assign wd_fire  = (counter == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (pick_vld) state_nxt = ACTIVE;
      ACTIVE: begin
        if (tx_pkt_end) begin
`ifdef USB_TX_ARB_IPG_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end else if (wd_fire) begin
          state_nxt = IDLE;
        end
      end
`ifdef USB_TX_ARB_IPG_EN
      GAP:    if (counter == CNT_W'(IPG_CYCLES - 1)) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= IDLE;
      pending      <= '0;
      grant        <= '0;
      last_grant   <= LG_W'(NUM_REQ - 1);
      tx_pkt_start <= 1'b0;
      tx_pid       <= 4'd0;
      timeout_err  <= 1'b0;
      counter      <= '0;
      for (int i = 0; i < NUM_REQ; i++) pid_q[i] <= 4'd0;
    end else begin
      state        <= state_nxt;
      tx_pkt_start <= 1'b0;
      timeout_err  <= 1'b0;
      // A strobe landing on the grant edge re-arms the slot it just cleared.
      pending      <= (pending & ~pick_clr) | req_pkt_start;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_pkt_start[i]) pid_q[i] <= req_pid[4*i +: 4];
      case (state)
        IDLE: begin
          counter <= '0;
          if (pick_vld) begin
            grant        <= pick_oh;
            last_grant   <= pick;
            tx_pid       <= pid_q[pick];
            tx_pkt_start <= 1'b1;
          end
        end
        ACTIVE: begin
          if (tx_pkt_end) begin
            grant   <= '0;
            counter <= '0;
          end else if (wd_fire) begin
            grant       <= '0;
            counter     <= '0;
            timeout_err <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
`ifdef USB_TX_ARB_IPG_EN
        GAP: counter <= (state_nxt == IDLE) ? '0 : counter + 1'b1;
`endif
        default: counter <= '0;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    tx_data       = 8'd0;
    tx_data_avail = 1'b0;
    req_data_get  = '0;
    req_pkt_end   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == ACTIVE && grant[i]) begin
        tx_data         = req_data[8*i +: 8];
        tx_data_avail   = req_data_avail[i];
        req_data_get[i] = tx_data_get;
        req_pkt_end[i]  = tx_pkt_end;
      end
    end
  end

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Directed and randomized bench for usb_fs_tx_arbiter against a transaction-level model.
module tb_usb_fs_tx_arbiter;

  localparam int N   = 3;
  localparam int TMO = 16;
  localparam int IPG = 4;
`ifdef USB_TX_ARB_IPG_EN
  localparam int GAP_LEN = IPG;
`else
  localparam int GAP_LEN = 0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_pkt_start = '0;
  logic [4*N-1:0] req_pid = '0;
  logic [N-1:0]   req_data_avail = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_data_get, req_pkt_end, grant;
  logic           tx_pkt_start, tx_data_avail, busy, timeout_err;
  logic [3:0]     tx_pid;
  logic [7:0]     tx_data;
  logic           tx_data_get = 1'b0;
  logic           tx_pkt_end = 1'b0;

  always #5 clk = ~clk;

  usb_fs_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .IPG_CYCLES(IPG)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_pkt_start(req_pkt_start), .req_pid(req_pid),
    .req_data_avail(req_data_avail), .req_data(req_data),
    .req_data_get(req_data_get), .req_pkt_end(req_pkt_end),
    .tx_pkt_start(tx_pkt_start), .tx_pid(tx_pid),
    .tx_data_avail(tx_data_avail), .tx_data(tx_data),
    .tx_data_get(tx_data_get), .tx_pkt_end(tx_pkt_end),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  // Model: who owns the path, when it was granted, and a slot per requester.
  bit         m_pend [N];
  logic [3:0] m_pid  [N];
  int         m_owner, m_last, m_gedge, m_edge, m_gap;
  logic [3:0] m_txpid;
  bit         m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_pid[i] = 4'd0; end
    m_owner = -1; m_last = N - 1; m_gedge = -100; m_edge = 0; m_gap = 0;
    m_txpid = 4'd0; m_tmo = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] own;
    own = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant", grant, own);
    chk("busy", busy, (m_owner >= 0 || m_gap > 0));
    chk("tx_pkt_start", tx_pkt_start, (m_owner >= 0 && m_edge == m_gedge));
    chk("timeout_err", timeout_err, m_tmo);
    if (m_owner >= 0) chk("tx_pid", tx_pid, m_txpid);
    chk("tx_data", tx_data, (m_owner >= 0) ? req_data[8*m_owner +: 8] : 8'd0);
    chk("tx_data_avail", tx_data_avail, (m_owner >= 0) ? req_data_avail[m_owner] : 1'b0);
    chk("req_data_get", req_data_get, tx_data_get ? own : 32'd0);
    chk("req_pkt_end", req_pkt_end, tx_pkt_end ? own : 32'd0);
  endtask

  task automatic model_edge();
    int nedge;
    nedge = m_edge + 1;
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (tx_pkt_end) begin
        m_owner = -1;
        m_gap   = GAP_LEN;
      end else if (nedge == m_gedge + TMO) begin
        m_owner = -1;
        m_tmo   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_owner < 0 && m_pend[idx]) begin
          m_owner = idx; m_last = idx; m_gedge = nedge;
          m_txpid = m_pid[idx]; m_pend[idx] = 0;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (req_pkt_start[i]) begin m_pend[i] = 1; m_pid[i] = req_pid[4*i +: 4]; end
    m_edge = nedge;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    req_pkt_start = '0;
    tx_pkt_end    = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      #1;
      if (tx_pkt_start === 1'b1) ok = 1;
      else cycle();
    end
    if (!ok) chk("wait_start_bound", 0, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_pkt_start = '0; tx_pkt_end = 1'b0; tx_data_get = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", tx_pkt_start, 0);
    chk("rst_pid", tx_pid, 0);
    chk("rst_tmo", timeout_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    int cnt;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request on requester 1.
    req_pkt_start = 3'b010; req_pid[7:4] = 4'b0010;
    cycle();
    cycle();
    #1;
    chk("single_start", tx_pkt_start, 1);
    chk("single_grant", grant, 3'b010);
    chk("single_pid", tx_pid, 4'b0010);
    repeat (8) cycle();
    tx_pkt_end = 1'b1;
    #1 chk("single_pkt_end", req_pkt_end, 3'b010);
    cycle();
    #1 chk("single_release", grant, 3'b000);
    cycle();

    // Simultaneous requests from reset: strict rotation 0,1,2.
    do_reset();
    req_pkt_start = 3'b111; req_pid = {4'b1110, 4'b1010, 4'b1001};
    cycle();
    for (int k = 0; k < N; k++) begin
      logic [11:0] pids;
      pids = {4'b1110, 4'b1010, 4'b1001};
      wait_start(10);
      chk("rot_grant", grant, 32'd1 << k);
      chk("rot_pid", tx_pid, pids[4*k +: 4]);
      tx_pkt_end = 1'b1;
      cycle();
    end
    cycle();
    req_pkt_start = 3'b101; req_pid = {4'b0111, 4'b0000, 4'b0101};
    cycle();
    wait_start(10);
    chk("wrap_grant0", grant, 3'b001);
    tx_pkt_end = 1'b1;
    cycle();
    wait_start(10);
    chk("wrap_grant2", grant, 3'b100);
    tx_pkt_end = 1'b1;
    cycle();

    // Data path through requester 2.
    req_pkt_start = 3'b100;
    cycle();
    wait_start(10);
    for (int b = 0; b < 4; b++) begin
      req_data[23:16] = 8'hA1 + 8'(b); req_data_avail = 3'b100; tx_data_get = 1'b1;
      #1;
      chk("dp_data", tx_data, 8'hA1 + 8'(b));
      chk("dp_get", req_data_get, 3'b100);
      chk("dp_avail", tx_data_avail, 1);
      cycle();
    end
    tx_data_get = 1'b0; req_data_avail = '0;
    tx_pkt_end = 1'b1;
    cycle();

    // Watchdog with a competitor waiting.
    req_pkt_start = 3'b010;
    cycle();
    wait_start(10);
    req_pkt_start = 3'b001;
    cnt = -1;
    for (int n = 0; n < 40 && cnt < 0; n++) begin
      #1;
      if (timeout_err === 1'b1) cnt = n;
      else cycle();
    end
    chk("wd_latency", cnt, TMO);
    chk("wd_grant", grant, 0);
    cycle();
    #1;
    chk("wd_next_start", tx_pkt_start, 1);
    chk("wd_next_grant", grant, 3'b001);

    // Asynchronous reset in the middle of a packet.
    req_pkt_start = 3'b010;
    cycle();
    req_data_avail = 3'b001; req_data[7:0] = 8'h5A;
    cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_start", tx_pkt_start, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    req_pkt_start = '0; req_data_avail = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      #1 if (tx_pkt_start === 1'b1) cnt++;
      cycle();
    end
    chk("arst_no_start", cnt, 0);

    // Gap between end of packet and the next start.
    req_pkt_start = 3'b001;
    cycle();
    wait_start(10);
    req_pkt_start = 3'b100;
    cycle();
    tx_pkt_end = 1'b1;
    cnt = -1;
    for (int n = 0; n < 20 && cnt < 0; n++) begin
      #1;
      if (n > 0 && tx_pkt_start === 1'b1) cnt = n;
      else cycle();
    end
    chk("ipg_latency", cnt, GAP_LEN + 2);
    tx_pkt_end = 1'b1;
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N; i++) req_pkt_start[i] = ($urandom_range(0, 5) == 0);
      req_pid        = 12'($urandom);
      req_data       = 24'($urandom);
      req_data_avail = 3'($urandom);
      tx_data_get    = $urandom_range(0, 1) == 1;
      tx_pkt_end     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_bound observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/usb_fs_tx_arbiter.md
Name: usb_fs_tx_arbiter

Overview:
- Shares the single full-speed USB transmit path between several protocol engines (IN PE, OUT PE handshakes, control/SETUP responder).
- Each engine issues a one-cycle packet-start strobe with a PID, plus a byte-stream data interface.
- Latches those requests, grants the tx path round-robin, and holds the grant until the serializer reports end of packet.
- Sits between the protocol engines and the tx serializer; a watchdog frees the path if the serializer never reports end of packet.

Parameters:
- NUM_REQ, 3, number of requesting protocol engines (1..8).
- TIMEOUT_CYCLES, 4096, cycles in ACTIVE without tx_pkt_end before the grant is forcibly released (≥16).
- IPG_CYCLES, 4, minimum idle cycles between tx_pkt_end and the next tx_pkt_start; used only with the optional feature.

Ports:
- clk  in  1  system clock (48 MHz domain); only clock.
- reset_n  in  1  asynchronous active-low reset.
- req_pkt_start  in  NUM_REQ  per-requester one-cycle strobe: send a packet.
- req_pid  in  4*NUM_REQ  PID for requester i in bits [4i+3:4i]; sampled with its strobe.
- req_data_avail  in  NUM_REQ  requester i has a payload byte ready.
- req_data  in  8*NUM_REQ  payload byte of requester i, bits [8i+7:8i].
- req_data_get  out  NUM_REQ  byte-consumed strobe back to the granted requester.
- req_pkt_end  out  NUM_REQ  one-cycle end-of-packet notice to the granted requester.
- tx_pkt_start  out  1  one-cycle strobe to serializer.
- tx_pid  out  4  PID to serializer, stable from tx_pkt_start until tx_pkt_end.
- tx_data_avail  out  1  granted requester's avail, gated by ACTIVE.
- tx_data  out  8  granted requester's byte.
- tx_data_get  in  1  serializer consumed tx_data.
- tx_pkt_end  in  1  serializer finished the packet.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, pending=0, pid_q=0, grant=0, last_grant=NUM_REQ-1.
  - tx_pkt_start=0, tx_pid=0, timeout_err=0, counter=0.
  - All outputs are 0 during reset.
- Request capture: req_pkt_start[i] sets pending[i] and loads pid_q[i] on the same edge.
  - A repeat strobe while pending[i]=1 overwrites pid_q[i]; the latest PID wins and there is one slot per requester.
  - A strobe from the currently granted requester during ACTIVE sets pending for a later turn.
- States:
  - IDLE: if any pending bit is set, pick the first pending index searching upward from last_grant+1 with wrap at NUM_REQ. On the next edge: grant<=onehot(g), last_grant<=g, tx_pid<=pid_q[g], tx_pkt_start<=1, pending[g]<=0, go ACTIVE. A strobe on the same edge as this clear re-sets pending[g] (set wins).
  - ACTIVE: tx_pkt_start is 0 after its first cycle.
    - tx_data = req_data[g]; tx_data_avail = req_data_avail[g]; req_data_get[g] = tx_data_get. These are combinational; non-granted bits are 0.
    - tx_pkt_end: req_pkt_end[g]=1 in the same cycle (combinational); next state IDLE (or GAP with the feature); grant<=0; counter<=0.
    - Counter increments each ACTIVE cycle. When it reaches TIMEOUT_CYCLES-1 without tx_pkt_end: timeout_err pulse, grant<=0, go IDLE. No req_pkt_end is issued and the pending state of other requesters is preserved.
- Latency: strobe at edge k → pending at k+1 → tx_pkt_start high after edge k+2 when idle with no competitors. After tx_pkt_end at edge m, the earliest next tx_pkt_start is after edge m+2 without the feature.
- tx_pkt_end or tx_data_get while IDLE: ignored, no output effect.
- All requests pending simultaneously: granted in strict rotation; no requester is served twice while another is pending.
- NUM_REQ=1: arbitration degenerates to pass-through with the same latency.

Optional Feature:
- Macro: USB_TX_ARB_IPG_EN.
- Defined: adds state GAP after tx_pkt_end. GAP counts IPG_CYCLES clocks with busy=1 and grant=0, then goes to IDLE. Requests arriving during GAP stay pending. The next tx_pkt_start comes no earlier than IPG_CYCLES+2 cycles after the tx_pkt_end edge.
- Undefined: GAP does not exist, ACTIVE returns directly to IDLE, and IPG_CYCLES is unused.

Test Plan:
- Single request: req_pkt_start[1] with pid 4'b0010 at cycle 10 → tx_pkt_start=1 at cycle 12, tx_pid=0010, grant=3'b010. tx_pkt_end at cycle 20 → req_pkt_end[1] at cycle 20, grant=0 at cycle 21.
- Simultaneous requests: strobes on all 3 with pids 1001, 1010, 1110 in one cycle, with an immediate tx_pkt_end after each start → served in order 0,1,2 with matching tx_pid. A later strobe on 0 then 2 → 0 served first (last_grant=2).
- Data path: grant to requester 2 with 4 bytes 0xA1..0xA4 and tx_data_get each cycle → tx_data sequence A1..A4; req_data_get[2] mirrors tx_data_get; req_data_get[0..1]=0.
- Watchdog: TIMEOUT_CYCLES=16 and no tx_pkt_end → timeout_err pulse 16 cycles after tx_pkt_start, grant=0; a pending request on requester 0 is then granted 1 cycle later.
- Reset mid-ACTIVE: drop reset_n during payload → grant, tx_pkt_start, and busy go 0 immediately (asynchronously), pending is cleared, and there is no tx_pkt_start after release until a new strobe.
- With USB_TX_ARB_IPG_EN and IPG_CYCLES=4: pending request at tx_pkt_end (edge m) → next tx_pkt_start not before edge m+6, with busy=1 throughout.
